// File: rtl/ifft_data_output_handler.sv
// Ping-pong buffer between an IFFT stream (real part kept) and an audio-rate sample tick.
// Define IFFT_OUT_SCALE_EN to store rounded, saturated (real >>> SCALE_SHIFT) instead of raw samples.
module ifft_data_output_handler #(
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned SCALE_SHIFT = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] tData,
    input  logic        tValid,
    input  logic        tLast,
    output logic        tReady,
    input  logic        sampleTick,
    output logic [15:0] sampleOut,
    output logic        sampleValid,
    output logic        underrun,
    output logic        frameError,
    output logic [1:0]  framesBuffered
);
    localparam int unsigned AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    logic [15:0]   mem [2*FRAME_LEN];
    logic [15:0]   rdata_q;

    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] wcount_q, wcount_d;
    logic [AW-1:0] rcount_q, rcount_d;
    logic          tready_q, tready_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    fb_q, fb_d;
    logic          rd_v1_q, rd_z1_q;
    logic          underrun_q;
    logic          svalid_q;
    logic [15:0]   sout_q;

    logic          wr_fire, wr_last, rd_hit, rd_last;
    logic [15:0]   wr_val;
    logic          unused_imag;

    assign unused_imag = ^{tData[31:16], 1'(SCALE_SHIFT)};

`ifdef IFFT_OUT_SCALE_EN
    // Round half-up, arithmetic shift, then clamp to the 16-bit signed range.
    localparam int unsigned RND = (1 << SCALE_SHIFT) >> 1;
    logic signed [17:0] rnd_sum;
    logic signed [17:0] shifted;

    always_comb begin
        rnd_sum = 18'(signed'(tData[15:0])) + $signed(18'(RND));
        shifted = rnd_sum >>> SCALE_SHIFT;
        if (shifted > 18'sd32767) begin
            wr_val = 16'h7FFF;
        end else if (shifted < -18'sd32768) begin
            wr_val = 16'h8000;
        end else begin
            wr_val = shifted[15:0];
        end
    end
`else
    assign wr_val = tData[15:0];
`endif

    // Bank bookkeeping: writer fills the non-full bank, reader drains the full one.
    always_comb begin
        wr_fire  = tValid && tready_q;
        wr_last  = wr_fire && (wcount_q == LAST_IDX);
        rd_hit   = sampleTick && full_q[rbank_q];
        rd_last  = rd_hit && (rcount_q == LAST_IDX);

        full_d   = full_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        wcount_d = wcount_q;
        rcount_d = rcount_q;
        ferr_d   = ferr_q;

        if (wr_fire) begin
            wcount_d = wcount_q + AW'(1);
            if (tLast != (wcount_q == LAST_IDX)) begin
                ferr_d = 1'b1;
            end
            if (wr_last) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcount_d        = '0;
            end
        end

        if (rd_hit) begin
            rcount_d = rcount_q + AW'(1);
            if (rd_last) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcount_d        = '0;
            end
        end

        tready_d = !full_d[wbank_d];
        fb_d     = 2'(full_d[0]) + 2'(full_d[1]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            full_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wcount_q   <= '0;
            rcount_q   <= '0;
            tready_q   <= 1'b0;
            ferr_q     <= 1'b0;
            fb_q       <= '0;
            rd_v1_q    <= 1'b0;
            rd_z1_q    <= 1'b0;
            underrun_q <= 1'b0;
            svalid_q   <= 1'b0;
            sout_q     <= '0;
        end else begin
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            wcount_q   <= wcount_d;
            rcount_q   <= rcount_d;
            tready_q   <= tready_d;
            ferr_q     <= ferr_d;
            fb_q       <= fb_d;
            rd_v1_q    <= sampleTick;
            rd_z1_q    <= sampleTick && !full_q[rbank_q];
            underrun_q <= sampleTick && !full_q[rbank_q];
            svalid_q   <= rd_v1_q;
            if (rd_v1_q) begin
                sout_q <= rd_z1_q ? 16'h0000 : rdata_q;
            end
        end
    end

    // Synchronous sample RAM; read and write never target the same bank.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem[{wbank_q, wcount_q}] <= wr_val;
        end
        rdata_q <= mem[{rbank_q, rcount_q}];
    end

    assign tReady         = tready_q;
    assign sampleOut      = sout_q;
    assign sampleValid    = svalid_q;
    assign underrun       = underrun_q;
    assign frameError     = ferr_q;
    assign framesBuffered = fb_q;

endmodule
